// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package boot_pkg;

   localparam int unsigned IMEM_WORDS = 43;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_HALT = 2'b11
   } boot_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low reset to 0.
module sync_2ff (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/imem_boot_controller.sv
// Sequences the core through program load (valid/ready stream into imem) and run phases,
// holding the pc in reset until a complete image has been written.
module imem_boot_controller
   import boot_pkg::*;
#(
   parameter int unsigned MEM_WORDS      = IMEM_WORDS,
   parameter int unsigned ADDR_W         = 6,
   parameter int unsigned MAX_RUN_CYCLES = 0,
   parameter int unsigned CNT_W          = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              run_switch,
   input  logic              src_valid,
   input  logic [31:0]       src_data,
   input  logic              src_last,
   output logic              src_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              imem_we,
   output logic              imem_re,
   output logic              cpu_reset,
   output logic              cpu_clk_en,
   output logic [ADDR_W:0]   load_words,
   output logic [CNT_W-1:0]  run_cycles,
   output logic [1:0]        state_o,
   output logic              err_overflow
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
   localparam bit                HALT_EN   = (MAX_RUN_CYCLES != 0);
   localparam logic [CNT_W-1:0]  HALT_AT   = CNT_W'(MAX_RUN_CYCLES - 1);

   boot_state_e       state_q;
   logic [ADDR_W-1:0] count_q;
   logic              loaded_q;
   // Set when a load ends; blocks re-entering LOAD until src_valid drops, so
   // surplus words of the finished stream are ignored rather than starting a new load.
   logic              drain_q;
   logic              rs_s;
   logic              beat;

   sync_2ff u_run_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (run_switch),
      .q       (rs_s)
   );

   assign src_ready = (state_q == ST_LOAD);
   assign beat      = src_valid & src_ready;
   assign state_o   = state_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         loaded_q     <= 1'b0;
         drain_q      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         imem_we      <= 1'b0;
         imem_re      <= 1'b0;
         cpu_reset    <= 1'b1;
         cpu_clk_en   <= 1'b0;
         load_words   <= '0;
         run_cycles   <= '0;
         err_overflow <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (!src_valid) drain_q <= 1'b0;

         unique case (state_q)
            ST_IDLE: begin
               if (rs_s && loaded_q) begin
                  state_q    <= ST_RUN;
                  cpu_reset  <= 1'b0;
                  cpu_clk_en <= 1'b1;
                  imem_re    <= 1'b1;
                  run_cycles <= '0;
               end else if (!rs_s && src_valid && !drain_q) begin
                  state_q      <= ST_LOAD;
                  count_q      <= '0;
                  load_words   <= '0;
                  loaded_q     <= 1'b0;
                  err_overflow <= 1'b0;
               end
            end

            ST_LOAD: begin
               if (beat) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= count_q;
                  imem_wdata <= src_data;
                  count_q    <= count_q + ADDR_W'(1);
                  if (src_last || (count_q == LAST_ADDR)) begin
                     state_q      <= ST_IDLE;
                     loaded_q     <= 1'b1;
                     drain_q      <= 1'b1;
                     load_words   <= {1'b0, count_q} + (ADDR_W + 1)'(1);
                     err_overflow <= ~src_last;
                  end
               end
            end

            ST_RUN: begin
               if (run_cycles != '1) run_cycles <= run_cycles + CNT_W'(1);
               if (!rs_s) begin
                  state_q    <= ST_IDLE;
                  cpu_reset  <= 1'b1;
                  cpu_clk_en <= 1'b0;
                  imem_re    <= 1'b0;
               end else if (HALT_EN && (run_cycles == HALT_AT)) begin
                  state_q    <= ST_HALT;
                  cpu_clk_en <= 1'b0;
                  imem_re    <= 1'b0;
               end
            end

            ST_HALT: begin
               if (!rs_s) begin
                  state_q   <= ST_IDLE;
                  cpu_reset <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_controller.sv
// Scoreboard bench for imem_boot_controller: unlimited-run and 10-cycle-limit instances share stimulus.
module tb_imem_boot_controller;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        run_switch;
   logic        src_valid;
   logic [31:0] src_data;
   logic        src_last;

   logic        src_ready, imem_we, imem_re, cpu_reset, cpu_clk_en, err_overflow;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [6:0]  load_words;
   logic [31:0] run_cycles;
   logic [1:0]  state_o;

   logic        h_src_ready, h_imem_we, h_imem_re, h_cpu_reset, h_cpu_clk_en, h_err_overflow;
   logic [5:0]  h_imem_addr;
   logic [31:0] h_imem_wdata;
   logic [6:0]  h_load_words;
   logic [31:0] h_run_cycles;
   logic [1:0]  h_state_o;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  exp_addr = 0;

   always #5 clock = ~clock;

   imem_boot_controller #(.MAX_RUN_CYCLES(0)) dut (
      .clock(clock), .reset_n(reset_n), .run_switch(run_switch),
      .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
      .src_ready(src_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .imem_we(imem_we), .imem_re(imem_re), .cpu_reset(cpu_reset),
      .cpu_clk_en(cpu_clk_en), .load_words(load_words), .run_cycles(run_cycles),
      .state_o(state_o), .err_overflow(err_overflow)
   );

   imem_boot_controller #(.MAX_RUN_CYCLES(10)) dut_h (
      .clock(clock), .reset_n(reset_n), .run_switch(run_switch),
      .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
      .src_ready(h_src_ready), .imem_addr(h_imem_addr), .imem_wdata(h_imem_wdata),
      .imem_we(h_imem_we), .imem_re(h_imem_re), .cpu_reset(h_cpu_reset),
      .cpu_clk_en(h_cpu_clk_en), .load_words(h_load_words), .run_cycles(h_run_cycles),
      .state_o(h_state_o), .err_overflow(h_err_overflow)
   );

   // Write monitor: every imem write must match the oldest expected beat.
   always @(negedge clock) begin
      if (reset_n && imem_we) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL imem_write_unexpected: got addr %0d data %h, required no write",
                     imem_addr, imem_wdata);
         end else begin
            wr_t e;
            e = sb.pop_front();
            if (int'(imem_addr) != e.addr || imem_wdata !== e.data) begin
               n_fail++;
               $display("FAIL imem_write: got addr %0d data %h, required addr %0d data %h",
                        imem_addr, imem_wdata, e.addr, e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Present one word and wait (bounded) for its beat; returns 1 time unit after the beat edge.
   task automatic send_word(input logic [31:0] d, input logic last);
      bit ok;
      wr_t e;
      ok = 1'b0;
      src_valid = 1'b1;
      src_data  = d;
      src_last  = last;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         if (src_ready) begin
            ok     = 1'b1;
            e.addr = exp_addr;
            e.data = d;
            sb.push_back(e);
            exp_addr++;
         end
         @(posedge clock);
         #1;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL handshake_timeout: got no src_ready for word %h, required a beat", d);
      end else begin
         chk("we_one_cycle_after_beat", imem_we, 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required end of test");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      run_switch = 1'b0;
      src_valid  = 1'b0;
      src_data   = '0;
      src_last   = 1'b0;
      tick(2);
      chk("rst_state", state_o, 0);
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_src_ready", src_ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_re", imem_re, 0);
      chk("rst_clk_en", cpu_clk_en, 0);
      chk("rst_err", err_overflow, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_load_words", load_words, 0);
      chk("rst_run_cycles", run_cycles, 0);
      reset_n = 1'b1;
      tick(1);
      chk("post_rst_state", state_o, 0);

      // 1: five-word load
      exp_addr = 0;
      for (int i = 1; i <= 5; i++) send_word(32'h2008_0000 + i, (i == 5));
      src_valid = 1'b0;
      src_last  = 1'b0;
      chk("t1_state_idle", state_o, 0);
      chk("t1_load_words", load_words, 5);
      chk("t1_cpu_reset", cpu_reset, 1);
      tick(1);
      chk("t1_sb_drained", sb.size(), 0);

      // 2: release core, 2 sync + 1 FSM cycles; 4: limited instance halts at 10
      run_switch = 1'b1;
      tick(1);
      chk("t2_cpu_reset_c1", cpu_reset, 1);
      tick(1);
      chk("t2_cpu_reset_c2", cpu_reset, 1);
      tick(1);
      chk("t2_cpu_reset_c3", cpu_reset, 0);
      chk("t2_state_run", state_o, 2);
      chk("t2_clk_en", cpu_clk_en, 1);
      chk("t2_imem_re", imem_re, 1);
      chk("t2_rc0", run_cycles, 0);
      for (int k = 1; k <= 3; k++) begin
         tick(1);
         chk("t2_rc_count", run_cycles, k);
      end
      tick(7);
      chk("t4_h_state_halt", h_state_o, 3);
      chk("t4_h_rc10", h_run_cycles, 10);
      chk("t4_h_clk_en", h_cpu_clk_en, 0);
      chk("t4_h_cpu_reset", h_cpu_reset, 0);
      tick(1);
      chk("t4_h_frozen_state", h_state_o, 3);
      chk("t4_h_frozen_rc", h_run_cycles, 10);
      chk("t4_unlimited_rc", run_cycles, 11);
      chk("t4_unlimited_state", state_o, 2);
      run_switch = 1'b0;
      tick(2);
      chk("t4_still_run", state_o, 2);
      tick(1);
      chk("t4_idle", state_o, 0);
      chk("t4_cpu_reset", cpu_reset, 1);
      chk("t4_h_idle", h_state_o, 0);
      chk("t4_h_cpu_reset", h_cpu_reset, 1);
      run_switch = 1'b1;
      tick(3);
      chk("t4_h_rerun", h_state_o, 2);
      chk("t4_h_rc_restart", h_run_cycles, 0);
      chk("t4_h_clk_en_again", h_cpu_clk_en, 1);
      tick(1);
      chk("t4_h_rc1", h_run_cycles, 1);
      run_switch = 1'b0;
      tick(3);
      chk("t4_back_idle", state_o, 0);

      // 3: overflow, 44 words with no src_last
      exp_addr = 0;
      for (int i = 0; i < 43; i++) send_word(32'hA000_0000 + i, 1'b0);
      src_data = 32'hA000_002B;
      chk("t3_state_idle", state_o, 0);
      chk("t3_src_ready", src_ready, 0);
      chk("t3_err", err_overflow, 1);
      chk("t3_load_words", load_words, 43);
      tick(2);
      chk("t3_src_ready_later", src_ready, 0);
      chk("t3_no_reload", state_o, 0);
      src_valid = 1'b0;
      tick(2);
      chk("t3_sb_drained", sb.size(), 0);

      // 6: switch toggles during load
      exp_addr = 0;
      send_word(32'h0000_0601, 1'b0);
      run_switch = 1'b1;
      send_word(32'h0000_0602, 1'b0);
      run_switch = 1'b0;
      send_word(32'h0000_0603, 1'b0);
      run_switch = 1'b1;
      send_word(32'h0000_0604, 1'b0);
      send_word(32'h0000_0605, 1'b1);
      src_valid = 1'b0;
      src_last  = 1'b0;
      chk("t6_idle", state_o, 0);
      chk("t6_load_words", load_words, 5);
      chk("t6_err_cleared", err_overflow, 0);
      tick(1);
      chk("t6_run", state_o, 2);
      chk("t6_cpu_reset", cpu_reset, 0);
      run_switch = 1'b0;
      tick(3);
      chk("t6_idle_again", state_o, 0);
      chk("t6_sb_drained", sb.size(), 0);

      // 5: reset mid-load
      exp_addr = 0;
      for (int i = 1; i <= 3; i++) send_word(32'h0000_0500 + i, 1'b0);
      reset_n   = 1'b0;
      src_valid = 1'b0;
      #2;
      chk("t5_state", state_o, 0);
      chk("t5_cpu_reset", cpu_reset, 1);
      chk("t5_imem_we", imem_we, 0);
      chk("t5_src_ready", src_ready, 0);
      chk("t5_addr", imem_addr, 0);
      chk("t5_load_words", load_words, 0);
      sb.delete();
      tick(1);
      reset_n    = 1'b1;
      run_switch = 1'b1;
      tick(6);
      chk("t5_stays_idle", state_o, 0);
      chk("t5_cpu_reset_held", cpu_reset, 1);
      chk("t5_h_stays_idle", h_state_o, 0);
      run_switch = 1'b0;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
